// File: rtl/seq_divider_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// The issuing pipeline holds the master side; the divider holds the slave side.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider for DIV/DIVU/REM/REMU, retiring one quotient bit per clock.
// Divide-by-zero and signed overflow finish in a single cycle without iterating.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             is_rem_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] final_res;

    // Operand preparation: op[0]==0 selects the signed variants, op[1] selects remainder.
    always_comb begin
        signed_op   = ~bus.op[0];
        a_neg       = signed_op & bus.a[WIDTH-1];
        b_neg       = signed_op & bus.b[WIDTH-1];
        a_abs       = a_neg ? -bus.a : bus.a;
        b_abs       = b_neg ? -bus.b : bus.b;
        div_zero    = (bus.b == '0);
        overflow    = signed_op && (bus.a == MIN) && (bus.b == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = bus.op[1] ? bus.a : '1;
        end else if (!bus.op[1]) begin
            special_res = MIN;
        end
    end

    // One restoring step; the sign bit of the WIDTH+1 bit difference is the borrow.
    always_comb begin
        r_shift   = {rem_q, quo_q[WIDTH-1]};
        diff      = r_shift + {1'b1, ~div_q} + {{WIDTH{1'b0}}, 1'b1};
        borrow    = diff[WIDTH];
        rem_d     = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], ~borrow};
        final_res = is_rem_q ? (neg_r_q ? -rem_d : rem_d)
                             : (neg_q_q ? -quo_d : quo_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            is_rem_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (div_zero || overflow) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            rem_q    <= '0;
                            quo_q    <= a_abs;
                            div_q    <= b_abs;
                            neg_q_q  <= a_neg ^ b_neg;
                            neg_r_q  <= a_neg;
                            is_rem_q <= bus.op[1];
                            count_q  <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        result_q <= final_res;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: each launch pushes the model's result and latency,
// each completion pops and compares.
module tb_seq_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } exp_t;

    exp_t scb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sd, q, r;
        e.lat = 33;
        if (b == 0) begin
            e.res = op[1] ? a : 32'hFFFF_FFFF;
            e.lat = 1;
        end else if (!op[0]) begin
            sa    = longint'($signed(a));
            sd    = longint'($signed(b));
            q     = sa / sd;
            r     = sa % sd;
            e.res = op[1] ? r[31:0] : q[31:0];
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.lat = 1;
        end else begin
            e.res = op[1] ? (a % b) : (a / b);
        end
        return e;
    endfunction

    // Drive start across exactly one rising edge and record the expectation.
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        scb.push_back(model(op, a, b));
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Returns at the falling edge where done is seen; edges counts the start edge as 1.
    task automatic wait_done(output int edges, output int busy_cyc, output bit timeout);
        edges    = 1;
        busy_cyc = 0;
        timeout  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) return;
            if (bus.busy) busy_cyc++;
            @(posedge clk);
            edges++;
        end
        timeout = 1'b1;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, need 0/0/0", bus.busy, bus.done, bus.result);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, need 0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_unsigned;
        logic [1:0] ops [2];
        int edges, bc;
        bit to;
        exp_t e;
        ops = '{2'b01, 2'b11};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            launch(ops[i], 32'd100, 32'd7);
            wait_done(edges, bc, to);
            e = scb.pop_front();
            checks++;
            if (to || bus.result !== e.res || edges != e.lat || bc != 32) begin
                errors++;
                $display("FAIL unsigned_op%0d: result=%h edges=%0d busy=%0d timeout=%0b, need %h/%0d/32",
                         ops[i], bus.result, edges, bc, to, e.res, e.lat);
            end
            $display("op=%b a=100 b=7 result=%h edges=%0d busy_cycles=%0d", ops[i], bus.result, edges, bc);
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.result !== e.res) begin
                errors++;
                $display("FAIL done_pulse_op%0d: done=%b result=%h, need 0/%h", ops[i], bus.done, bus.result, e.res);
            end
        end
    endtask

    task automatic test_signed;
        logic [1:0]   ops [4];
        logic [W-1:0] av  [4];
        logic [W-1:0] bv  [4];
        logic [W-1:0] req [4];
        int edges, bc;
        bit to;
        exp_t e;
        ops = '{2'b00, 2'b10, 2'b00, 2'b10};
        av  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
        bv  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        req = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            launch(ops[i], av[i], bv[i]);
            wait_done(edges, bc, to);
            e = scb.pop_front();
            checks++;
            if (to || bus.result !== e.res || bus.result !== req[i] || edges != e.lat) begin
                errors++;
                $display("FAIL signed_%0d: result=%h edges=%0d timeout=%0b, need %h/%0d",
                         i, bus.result, edges, to, req[i], e.lat);
            end
            $display("op=%b a=%h b=%h result=%h edges=%0d", ops[i], av[i], bv[i], bus.result, edges);
        end
    endtask

    task automatic test_special;
        logic [1:0]   ops [6];
        logic [W-1:0] av  [6];
        logic [W-1:0] bv  [6];
        logic [W-1:0] req [6];
        int           lat [6];
        int edges, bc;
        bit to;
        exp_t e;
        ops = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01};
        av  = '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        bv  = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        req = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0};
        lat = '{1, 1, 1, 1, 1, 33};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            launch(ops[i], av[i], bv[i]);
            wait_done(edges, bc, to);
            e = scb.pop_front();
            checks++;
            if (to || bus.result !== e.res || bus.result !== req[i] || edges != lat[i] ||
                (lat[i] == 1 && (bc != 0 || bus.busy !== 1'b0))) begin
                errors++;
                $display("FAIL special_%0d: result=%h edges=%0d busy=%0d timeout=%0b, need %h/%0d",
                         i, bus.result, edges, bc, to, req[i], lat[i]);
            end
            $display("op=%b a=%h b=%h result=%h edges=%0d busy_cycles=%0d", ops[i], av[i], bv[i], bus.result, edges, bc);
        end
    endtask

    task automatic test_ignored_start;
        int edges, bc;
        bit to;
        exp_t e;
        @(negedge clk);
        launch(2'b01, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd999;
        bus.b     = 32'd10;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(edges, bc, to);
        e = scb.pop_front();
        checks++;
        if (to || bus.result !== e.res || bus.result !== 32'd14) begin
            errors++;
            $display("FAIL ignored_start: result=%h timeout=%0b, need %h", bus.result, to, e.res);
        end
        $display("ignored start mid-run: result=%h", bus.result);
    endtask

    task automatic test_reset_abort;
        int edges, bc, extra;
        bit to;
        exp_t e;
        @(negedge clk);
        launch(2'b01, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
            errors++;
            $display("FAIL async_abort: busy=%b done=%b result=%h, need 0/0/0", bus.busy, bus.done, bus.result);
        end
        void'(scb.pop_front());
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL no_done_after_abort: active_cycles=%0d, need 0", extra);
        end
        launch(2'b00, 32'hFFFF_FFF9, 32'd2);
        wait_done(edges, bc, to);
        e = scb.pop_front();
        checks++;
        if (to || bus.result !== e.res || edges != e.lat) begin
            errors++;
            $display("FAIL after_abort: result=%h edges=%0d, need %h/%0d", bus.result, edges, e.res, e.lat);
        end
        $display("after abort DIV -7/2: result=%h edges=%0d", bus.result, edges);
    endtask

    task automatic test_back_to_back;
        int edges, bc;
        bit to;
        exp_t e;
        @(negedge clk);
        launch(2'b01, 32'd100, 32'd7);
        wait_done(edges, bc, to);
        e = scb.pop_front();
        checks++;
        if (to || bus.result !== e.res) begin
            errors++;
            $display("FAIL b2b_first: result=%h, need %h", bus.result, e.res);
        end
        launch(2'b01, 32'hFFFF_FFFF, 32'd1);
        wait_done(edges, bc, to);
        e = scb.pop_front();
        checks++;
        if (to || bus.result !== 32'hFFFF_FFFF || bus.result !== e.res || edges != 33) begin
            errors++;
            $display("FAIL b2b_second: result=%h edges=%0d timeout=%0b, need ffffffff/33", bus.result, edges, to);
        end
        $display("back-to-back DIVU ffffffff/1: result=%h edges=%0d", bus.result, edges);
    endtask

    task automatic test_random;
        logic [1:0]   op;
        logic [W-1:0] a, b;
        int edges, bc;
        bit to;
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if (i % 8 == 7) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            @(negedge clk);
            launch(op, a, b);
            wait_done(edges, bc, to);
            e = scb.pop_front();
            checks++;
            if (to || bus.result !== e.res || edges != e.lat) begin
                errors++;
                $display("FAIL random_%0d: op=%b a=%h b=%h result=%h edges=%0d, need %h/%0d",
                         i, op, a, b, bus.result, edges, e.res, e.lat);
            end
            $display("op=%b a=%h b=%h result=%h edges=%0d", op, a, b, bus.result, edges);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
